// File: rtl/imm_ext_pipe.sv
// Immediate extender behind a 2-entry elastic buffer (head + skid).
// The extension is computed on acceptance, so only the extended value and its sign flag are stored.
module imm_ext_pipe #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16,
  parameter int W0    = 5,
  parameter int W1    = 8,
  parameter int W2    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_neg
);

  // Keep the low F bits and fill everything above them with the field sign, or with zeros.
  function automatic logic [OUT_W-1:0] ext_f(input logic [IN_W-1:0] raw,
                                             input logic [1:0] md,
                                             input logic s);
    int              fw;
    logic [IN_W-1:0] mask;
    logic [IN_W-1:0] sel;
    logic            fill;
    case (md)
      2'd0:    fw = W0;
      2'd1:    fw = W1;
      2'd2:    fw = W2;
      default: fw = IN_W;
    endcase
    mask = {IN_W{1'b1}} >> (IN_W - fw);
    sel  = IN_W'(1) << (fw - 1);
    fill = s & (|(raw & sel));
    return OUT_W'(raw & mask) | ({OUT_W{fill}} & ~OUT_W'(mask));
  endfunction

  logic [OUT_W-1:0] r_head_data;
  logic             r_head_neg;
  logic             r_head_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic             r_skid_neg;
  logic             r_skid_valid;
  logic             r_in_ready;

  logic [OUT_W-1:0] w_ext;
  logic             w_acc;
  logic             w_pop;
  logic [OUT_W-1:0] w_head_data_nxt;
  logic             w_head_neg_nxt;
  logic             w_head_valid_nxt;
  logic [OUT_W-1:0] w_skid_data_nxt;
  logic             w_skid_neg_nxt;
  logic             w_skid_valid_nxt;

  assign w_ext = ext_f(in, mode, sgn);
  assign w_acc = in_valid & r_in_ready;
  assign w_pop = r_head_valid & out_ready;

  // Head/skid steering: skid drains into the head before a new input may land in the head.
  always_comb begin
    w_head_data_nxt  = r_head_data;
    w_head_neg_nxt   = r_head_neg;
    w_head_valid_nxt = r_head_valid;
    w_skid_data_nxt  = r_skid_data;
    w_skid_neg_nxt   = r_skid_neg;
    w_skid_valid_nxt = r_skid_valid;
    if (!r_head_valid || w_pop) begin
      if (r_skid_valid) begin
        w_head_data_nxt  = r_skid_data;
        w_head_neg_nxt   = r_skid_neg;
        w_head_valid_nxt = 1'b1;
        if (w_acc) begin
          w_skid_data_nxt = w_ext;
          w_skid_neg_nxt  = w_ext[OUT_W-1];
        end else begin
          w_skid_valid_nxt = 1'b0;
        end
      end else begin
        w_head_valid_nxt = w_acc;
        if (w_acc) begin
          w_head_data_nxt = w_ext;
          w_head_neg_nxt  = w_ext[OUT_W-1];
        end else begin
          w_head_data_nxt = r_head_data;
        end
      end
    end else begin
      if (w_acc) begin
        w_skid_data_nxt  = w_ext;
        w_skid_neg_nxt   = w_ext[OUT_W-1];
        w_skid_valid_nxt = 1'b1;
      end else begin
        w_skid_valid_nxt = r_skid_valid;
      end
    end
  end

  // State update; in_ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_data  <= {OUT_W{1'b0}};
      r_head_neg   <= 1'b0;
      r_head_valid <= 1'b0;
      r_skid_data  <= {OUT_W{1'b0}};
      r_skid_neg   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_head_data  <= w_head_data_nxt;
      r_head_neg   <= w_head_neg_nxt;
      r_head_valid <= w_head_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_neg   <= w_skid_neg_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_head_valid;
  assign out       = r_head_data;
  assign out_neg   = r_head_neg;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed + random bench for imm_ext_pipe with a queue scoreboard and a shift-based reference model.
module tb_imm_ext_pipe;
  localparam int IN_W  = 11;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in;
  logic [1:0]       mode;
  logic             sgn;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out;
  logic             out_neg;

  logic [OUT_W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  logic [OUT_W-1:0] val_a;
  logic [OUT_W-1:0] val_b;
  logic [OUT_W-1:0] val_c;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .W0(5), .W1(8), .W2(11)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .mode(mode), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_neg(out_neg)
  );

  // Place the field at the top of a 16-bit word, then shift it back down arithmetically or logically.
  function automatic logic [15:0] ref_ext(input logic [10:0] raw, input logic [1:0] md, input logic s);
    int f;
    logic [10:0] sh;
    logic [15:0] full;
    f = (md == 2'd0) ? 5 : (md == 2'd1) ? 8 : 11;
    sh = raw << (11 - f);
    full = {sh, 5'b00000};
    if (s) return $signed(full) >>> (16 - f);
    else   return full >> (16 - f);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: score the output and input handshakes that the coming edge will complete.
  task automatic tick();
    logic [OUT_W-1:0] e;
    if (out_valid && out_ready) begin
      n_chk++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_out observed=%0h expected=none", out);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_out", 32'(out), 32'(e));
        chk("sb_out_neg", 32'(out_neg), 32'(e[15]));
        n_out++;
      end
    end
    if (in_valid && in_ready) exp_q.push_back(ref_ext(in, mode, sgn));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] v, input logic [1:0] md, input logic s);
    in_valid = 1'b1;
    in       = v;
    mode     = md;
    sgn      = s;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = '0; mode = 2'd0; sgn = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_neg", 32'(out_neg), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // Directed extension vectors, one accept per cycle with out_ready high.
    out_ready = 1'b1;
    drive(11'h01F, 2'd0, 1'b1); tick();
    chk("v1_out", 32'(out), 32'h0000FFFF);
    chk("v1_neg", 32'(out_neg), 32'd1);
    drive(11'h01F, 2'd0, 1'b0); tick();
    chk("v2_out", 32'(out), 32'h0000001F);
    chk("v2_neg", 32'(out_neg), 32'd0);
    drive(11'h780, 2'd1, 1'b1); tick();
    chk("v3_out", 32'(out), 32'h0000FF80);
    drive(11'h400, 2'd2, 1'b1); tick();
    chk("v4_out", 32'(out), 32'h0000FC00);
    drive(11'h7FF, 2'd3, 1'b0); tick();
    chk("v5_out", 32'(out), 32'h000007FF);
    drive(11'h7EF, 2'd0, 1'b1); tick();
    chk("v6_out", 32'(out), 32'h0000000F);
    chk("v6_neg", 32'(out_neg), 32'd0);
    in_valid = 1'b0; tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: A and B buffered, C stalled until release.
    out_ready = 1'b0;
    val_a = ref_ext(11'h155, 2'd1, 1'b1);
    val_b = ref_ext(11'h0AA, 2'd3, 1'b0);
    val_c = ref_ext(11'h012, 2'd0, 1'b1);
    drive(11'h155, 2'd1, 1'b1); tick();
    chk("bp_a_in_ready", 32'(in_ready), 32'd1);
    drive(11'h0AA, 2'd3, 1'b0); tick();
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_a", 32'(out), 32'(val_a));
    drive(11'h012, 2'd0, 1'b1); tick();
    chk("bp_hold_a2", 32'(out), 32'(val_a));
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_a3", 32'(out), 32'(val_a));
    chk("bp_hold_neg", 32'(out_neg), 32'(val_a[15]));
    out_ready = 1'b1; tick();
    chk("bp_out_b", 32'(out), 32'(val_b));
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_out_c", 32'(out), 32'(val_c));
    in_valid = 1'b0; tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Random stream at full rate: every cycle after the first must present a result.
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      drive(11'($urandom_range(0, 2047)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (i > 0) chk("stream_no_bubble", 32'(out_valid), 32'd1);
      if (i > 0) chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0; tick();
    chk("stream_count", 32'(n_out), 32'd100);
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Reset with two entries buffered.
    out_ready = 1'b0;
    drive(11'h3C3, 2'd2, 1'b1); tick();
    drive(11'h111, 2'd1, 1'b0); tick();
    in_valid = 1'b0;
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    chk("async_rst_out", 32'(out), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("no_stale", 32'(out_valid), 32'd0);
      tick();
    end
    drive(11'h050, 2'd1, 1'b1); tick();
    chk("post_rst_out", 32'(out), 32'(ref_ext(11'h050, 2'd1, 1'b1)));
    in_valid = 1'b0; tick();
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
